// File: rtl/imem_program_loader.sv
// Loads a length-prefixed, big-endian byte stream into the 128x16 instruction memory
// and holds the processor in reset until the whole program has been written.
module imem_program_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic [ADDR_W-1:0] Imem_Addr,
    output logic [15:0]       Imem_Data,
    output logic              Imem_Wr,
    output logic              CPU_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              Bad_Opcode,
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [7:0]        len_q;
    logic [7:0]        hi_q;
    logic              last_word;

    assign last_word = (index == ADDR_W'(len_q - 8'd1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            index      <= '0;
            len_q      <= '0;
            hi_q       <= '0;
            Imem_Addr  <= '0;
            Imem_Data  <= '0;
            Bad_Opcode <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        state      <= S_LEN;
                        Bad_Opcode <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (Byte_Valid) begin
                        if (Byte_In == 8'd0 || 32'(Byte_In) > DEPTH) begin
                            state <= S_ERR;
                        end else begin
                            len_q <= Byte_In;
                            index <= '0;
                            state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (Byte_Valid) begin
                        hi_q  <= Byte_In;
                        state <= S_LO;
                    end
                end
                // Address/data are loaded here so they are stable for the whole WRITE
                // cycle and simply hold afterwards; the opcode flag rises with them.
                S_LO: begin
                    if (Byte_Valid) begin
                        Imem_Addr <= index;
                        Imem_Data <= {hi_q, Byte_In};
                        if (hi_q[7:4] > 4'h5) begin
                            Bad_Opcode <= 1'b1;
                        end
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        state <= S_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Imem_Wr    = (state == S_WRITE);
    assign Byte_Ready = (state == S_LEN) || (state == S_HI) || (state == S_LO);
    assign Busy       = Byte_Ready || (state == S_WRITE);
    assign Done       = (state == S_DONE);
    assign Error      = (state == S_ERR);
    assign CPU_Reset  = (state != S_DONE);
    assign State      = state;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: writes are scored against a queue of
// expected {address, data} entries pushed as each low byte is driven.
module tb_imem_program_loader;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic [6:0]  Imem_Addr;
    logic [15:0] Imem_Data;
    logic        Imem_Wr;
    logic        CPU_Reset;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic        Bad_Opcode;
    logic [2:0]  State;

    imem_program_loader #(.ADDR_W(7), .DEPTH(128)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Imem_Addr  (Imem_Addr),
        .Imem_Data  (Imem_Data),
        .Imem_Wr    (Imem_Wr),
        .CPU_Reset  (CPU_Reset),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .Bad_Opcode (Bad_Opcode),
        .State      (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_count = 0;
    logic        exp_bad = 1'b0;
    logic        bad_pending = 1'b0;
    logic [22:0] sb[$];
    logic [15:0] prog[$];

    always @(posedge Clock) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: scoreboard pop, no-ready-in-WRITE, sticky opcode flag model.
    always @(negedge Clock) begin
        logic [22:0] e;
        if (bad_pending) begin
            check("bad_opcode", {31'd0, Bad_Opcode}, {31'd0, exp_bad});
            bad_pending = 1'b0;
        end
        if (Imem_Wr === 1'b1) begin
            wr_count++;
            check("wr_ready", {31'd0, Byte_Ready}, 32'd0);
            if (sb.size() == 0) begin
                check("wr_unexpected", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {25'd0, Imem_Addr}, {25'd0, e[22:16]});
                check("wr_data", {16'd0, Imem_Data}, {16'd0, e[15:0]});
                if (e[15:12] > 4'h5) exp_bad = 1'b1;
                bad_pending = 1'b1;
            end
        end
    end

    task automatic do_start();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        exp_bad = 1'b0;
        check("start_state", {29'd0, State}, 32'd1);
        check("start_cpurst", {31'd0, CPU_Reset}, 32'd1);
        check("start_badop", {31'd0, Bad_Opcode}, 32'd0);
        check("start_error", {31'd0, Error}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        Byte_In = b;
        Byte_Valid = 1'b1;
        t = 0;
        while (Byte_Ready !== 1'b1 && t < 50) begin
            @(negedge Clock);
            t++;
        end
        if (Byte_Ready !== 1'b1) check("ready_timeout", {31'd0, Byte_Ready}, 32'd1);
        @(negedge Clock);
    endtask

    // Streams prog[0..n-1]; optional stall before byte stall_at (odd index = LO state),
    // optional Start held during the stall, and early return before byte abort_at.
    task automatic stream(input int n, input int stall_at, input int stall_len,
                          input bit start_in_stall, input int abort_at);
        logic [15:0] w;
        for (int j = 0; j < 2 * n; j++) begin
            w = prog[j / 2];
            if (j == abort_at) return;
            if (j == stall_at) begin
                Byte_Valid = 1'b0;
                Start = start_in_stall;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge Clock);
                    check("stall_state", {29'd0, State}, (j % 2 == 0) ? 32'd2 : 32'd3);
                    check("stall_wr", {31'd0, Imem_Wr}, 32'd0);
                end
                Start = 1'b0;
            end
            if (j % 2 == 1) sb.push_back({7'(j / 2), w});
            send_byte((j % 2 == 0) ? w[15:8] : w[7:0]);
        end
    endtask

    task automatic load(input logic [7:0] len, input int stall_at, input int stall_len,
                        input bit start_in_stall, input bit expect_err);
        int len_cyc;
        int wr0;
        int t;
        int n;
        n = int'(len);
        wr0 = wr_count;
        do_start();
        send_byte(len);
        len_cyc = cyc;
        if (expect_err) begin
            Byte_Valid = 1'b0;
            repeat (3) @(negedge Clock);
            check("err_state", {29'd0, State}, 32'd6);
            check("err_flag", {31'd0, Error}, 32'd1);
            check("err_cpurst", {31'd0, CPU_Reset}, 32'd1);
            check("err_busy", {31'd0, Busy}, 32'd0);
            check("err_nowr", wr_count, wr0);
            return;
        end
        stream(n, stall_at, stall_len, start_in_stall, -1);
        Byte_Valid = 1'b0;
        t = 0;
        while (Done !== 1'b1 && t < 100) begin
            @(negedge Clock);
            t++;
        end
        check("done", {31'd0, Done}, 32'd1);
        if (stall_len == 0) check("done_latency", cyc - len_cyc, 3 * n);
        check("done_cpurst", {31'd0, CPU_Reset}, 32'd0);
        check("done_error", {31'd0, Error}, 32'd0);
        check("done_busy", {31'd0, Busy}, 32'd0);
        check("done_writes", wr_count - wr0, n);
        check("done_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Byte_In = 8'h00;
        Byte_Valid = 1'b0;
        #12;
        check("rst_state", {29'd0, State}, 32'd0);
        check("rst_cpurst", {31'd0, CPU_Reset}, 32'd1);
        check("rst_ready", {31'd0, Byte_Ready}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_error", {31'd0, Error}, 32'd0);
        check("rst_wr", {31'd0, Imem_Wr}, 32'd0);
        check("rst_addr", {25'd0, Imem_Addr}, 32'd0);
        check("rst_data", {16'd0, Imem_Data}, 32'd0);
        check("rst_badop", {31'd0, Bad_Opcode}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Ten-word program, valid held high, then with a 4-cycle stall before B1.
        prog = '{16'h0000, 16'h20B1, 16'h21B2, 16'h2063, 16'h28A4,
                 16'h4125, 16'h4346, 16'h3560, 16'h10CD, 16'h5000};
        load(8'd10, -1, 0, 1'b0, 1'b0);
        check("p10_badop", {31'd0, Bad_Opcode}, 32'd0);
        load(8'd10, 3, 4, 1'b0, 1'b0);

        // Out-of-range opcode is flagged but the load completes.
        prog = '{16'h7123, 16'h0000};
        load(8'd2, -1, 0, 1'b0, 1'b0);
        check("p2_badop", {31'd0, Bad_Opcode}, 32'd1);

        // Rejected lengths, then recovery from ERR.
        load(8'd0, -1, 0, 1'b0, 1'b1);
        load(8'd129, -1, 0, 1'b0, 1'b1);
        prog = '{16'h5000};
        load(8'd1, -1, 0, 1'b0, 1'b0);

        // Full-depth program with Start held during a stall.
        prog.delete();
        for (int i = 0; i < 128; i++) prog.push_back({4'($urandom_range(0, 7)), 12'($urandom)});
        load(8'd128, 11, 4, 1'b1, 1'b0);
        check("p128_last_addr", {25'd0, Imem_Addr}, 32'd127);

        // Asynchronous reset in LO of the third word, then a clean reload.
        prog = '{16'h0000, 16'h20B1, 16'h21B2, 16'h2063, 16'h28A4};
        do_start();
        send_byte(8'd5);
        stream(5, -1, 0, 1'b0, 5);
        Byte_Valid = 1'b0;
        check("pre_rst_state", {29'd0, State}, 32'd3);
        #2;
        Reset = 1'b1;
        exp_bad = 1'b0;
        #1;
        check("arst_state", {29'd0, State}, 32'd0);
        check("arst_cpurst", {31'd0, CPU_Reset}, 32'd1);
        check("arst_wr", {31'd0, Imem_Wr}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_sb", sb.size(), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        load(8'd5, -1, 0, 1'b0, 1'b0);

        repeat (2) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
